// File: rtl/seg_scan_pkg.sv
// Shared constants for the AHB-Lite multiplexed 7-segment scan controller:
// register offsets, CTRL field positions, AHB encodings and the hex segment table.
package seg_scan_pkg;

  // Word index within the 32-byte register window (HADDR[4:2])
  typedef enum logic [2:0] {
    REG_DATA   = 3'd0,
    REG_DPMASK = 3'd1,
    REG_BLANK  = 3'd2,
    REG_CTRL   = 3'd3,
    REG_STATUS = 3'd4
  } reg_sel_e;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_DUTY_LSB = 8;
  localparam int CTRL_DIV_LSB  = 16;
  localparam int STATUS_EN_BIT = 8;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  // Active-high {g,f,e,d,c,b,a}; entry 0 is the rightmost element
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_scan_timer.sv
// Scan timebase: clock-enable tick counter, digit index and, with SEG_DIM_EN
// defined, a 16-step PWM phase that stretches each digit slot to 16 ticks.
module seg_scan_timer
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 8
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        en,
  input  logic        clr,
  input  logic [15:0] div,
`ifdef SEG_DIM_EN
  input  logic [3:0]  duty,
`endif
  output logic [2:0]  idx,
  output logic        active
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [15:0] cnt;
  logic        tick;
  logic        slot_end;

  assign tick = en && (cnt == div);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 16'd1;
    end
  end

`ifdef SEG_DIM_EN
  logic [3:0] phase;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      phase <= '0;
    end else if (tick) begin
      phase <= phase + 4'd1;
    end
  end

  assign slot_end = tick && (phase == 4'hF);
  assign active   = (phase <= duty);
`else
  assign slot_end = tick;
  assign active   = 1'b1;
`endif

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      idx <= '0;
    end else if (slot_end) begin
      idx <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
    end
  end

endmodule

// File: rtl/ahb_seg_scan_ctrl.sv
// AHB-Lite slave driving a multiplexed 7-segment display of up to 8 hex digits.
// Define SEG_DIM_EN to add the CTRL.DUTY brightness control.
module ahb_seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int          NUM_DIGITS     = 8,
  parameter logic [15:0] DIV_RESET      = 16'h0070,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          AN_ACTIVE_LOW  = 1'b0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic                  HREADY,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);

  localparam logic [7:0]            DIGIT_MASK = 8'((9'd1 << NUM_DIGITS) - 9'd1);
  localparam logic [NUM_DIGITS-1:0] AN_DIGIT0  = NUM_DIGITS'(1);

  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      HSIZE_BYTE: byte_lanes = 4'b0001 << lane;
      HSIZE_HALF: byte_lanes = lane[1] ? 4'b1100 : 4'b0011;
      default:    byte_lanes = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [3:0] be);
    for (int b = 0; b < 4; b++) begin
      merge_lanes[8*b +: 8] = be[b] ? wdata[8*b +: 8] : old[8*b +: 8];
    end
  endfunction

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    hex_seg = SEG_LUT[nib];
  endfunction

  logic accept;
  logic vld_p0;
  logic write_p0;
  logic [2:0] reg_p0;
  logic [1:0] lane_p0;
  logic [2:0] size_p0;
  logic unused_haddr;

  assign accept       = HSEL && HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign unused_haddr = ^HADDR[31:5];
  assign HREADYOUT    = 1'b1;
  assign HRESP        = 1'b0;

  // Address phase -> data phase
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= accept;
    end
  end

  always_ff @(posedge HCLK) begin
    if (accept) begin
      write_p0 <= HWRITE;
      reg_p0   <= HADDR[4:2];
      lane_p0  <= HADDR[1:0];
      size_p0  <= HSIZE;
    end
  end

  logic        wr_en;
  logic [3:0]  be;
  logic [31:0] data_q;
  logic [7:0]  dpmask_q;
  logic [7:0]  blank_q;
  logic        en_q;
  logic [15:0] div_q;
`ifdef SEG_DIM_EN
  logic [3:0]  duty_q;
`endif

  assign wr_en = vld_p0 && write_p0;
  assign be    = byte_lanes(size_p0, lane_p0);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      data_q   <= '0;
      dpmask_q <= '0;
      blank_q  <= '0;
      en_q     <= 1'b1;
      div_q    <= DIV_RESET;
`ifdef SEG_DIM_EN
      duty_q   <= 4'hF;
`endif
    end else if (wr_en) begin
      case (reg_p0)
        REG_DATA:   data_q <= merge_lanes(data_q, HWDATA, be);
        REG_DPMASK: if (be[0]) dpmask_q <= HWDATA[7:0] & DIGIT_MASK;
        REG_BLANK:  if (be[0]) blank_q <= HWDATA[7:0] & DIGIT_MASK;
        REG_CTRL: begin
          if (be[0]) en_q <= HWDATA[CTRL_EN_BIT];
`ifdef SEG_DIM_EN
          if (be[1]) duty_q <= HWDATA[CTRL_DUTY_LSB +: 4];
`endif
          if (be[2]) div_q[7:0]  <= HWDATA[CTRL_DIV_LSB +: 8];
          if (be[3]) div_q[15:8] <= HWDATA[CTRL_DIV_LSB + 8 +: 8];
        end
        default: ;
      endcase
    end
  end

  logic [2:0] idx;
  logic       active;

  seg_scan_timer #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_timer (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .en     (en_q),
    .clr    (wr_en && (reg_p0 == REG_CTRL)),
    .div    (div_q),
`ifdef SEG_DIM_EN
    .duty   (duty_q),
`endif
    .idx    (idx),
    .active (active)
  );

  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    case (reg_p0)
      REG_DATA:   rd_word = data_q;
      REG_DPMASK: rd_word[7:0] = dpmask_q;
      REG_BLANK:  rd_word[7:0] = blank_q;
      REG_CTRL: begin
        rd_word[CTRL_EN_BIT]        = en_q;
        rd_word[CTRL_DIV_LSB +: 16] = div_q;
`ifdef SEG_DIM_EN
        rd_word[CTRL_DUTY_LSB +: 4] = duty_q;
`endif
      end
      REG_STATUS: begin
        rd_word[2:0]          = idx;
        rd_word[STATUS_EN_BIT] = en_q;
      end
      default: ;
    endcase
    HRDATA = (vld_p0 && !write_p0) ? rd_word : '0;
  end

  logic [6:0]            seg_nxt;
  logic                  dp_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]            seg_p1;
  logic                  dp_p1;
  logic [NUM_DIGITS-1:0] an_p1;

  always_comb begin
    seg_nxt = blank_q[idx] ? 7'h00 : hex_seg(data_q[{idx, 2'b00} +: 4]);
    dp_nxt  = dpmask_q[idx] && !blank_q[idx];
    an_nxt  = (en_q && active) ? (AN_DIGIT0 << idx) : '0;
    if (!en_q) begin
      seg_nxt = 7'h00;
      dp_nxt  = 1'b0;
    end
  end

  // Registered pins, polarity applied last
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      seg_p1 <= SEG_LUT[0] ^ {7{SEG_ACTIVE_LOW}};
      dp_p1  <= SEG_ACTIVE_LOW;
      an_p1  <= AN_DIGIT0 ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
    end else begin
      seg_p1 <= seg_nxt ^ {7{SEG_ACTIVE_LOW}};
      dp_p1  <= dp_nxt ^ SEG_ACTIVE_LOW;
      an_p1  <= an_nxt ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
    end
  end

  assign seg = seg_p1;
  assign dp  = dp_p1;
  assign an  = an_p1;

endmodule

// File: tb/tb_ahb_seg_scan_ctrl.sv
// Directed bench for ahb_seg_scan_ctrl: 8 digits, scan divider reset to 0.
module tb_ahb_seg_scan_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;

  int checks = 0;
  int errors = 0;

  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  ahb_seg_scan_ctrl #(
    .NUM_DIGITS(8), .DIV_RESET(16'h0000), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic int an_to_idx(input logic [7:0] a);
    an_to_idx = -1;
    if ($onehot(a)) begin
      for (int b = 0; b < 8; b++) if (a[b]) an_to_idx = b;
    end
  endfunction

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HSIZE = 3'b010; HWDATA = '0;
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr; HSIZE = size;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    @(posedge HCLK); #1;
    HWDATA = '0;
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    data = HRDATA;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    HRESET = 1'b1; HREADY = 1'b1; bus_idle();
    repeat (3) @(posedge HCLK);
    #1;
    checks++;
    if (an !== 8'h01 || seg !== 7'h3F || dp !== 1'b0) begin
      errors++;
      $display("FAIL reset_pins: an=%h seg=%h dp=%b, expected an=01 seg=3f dp=0", an, seg, dp);
    end
    HRESET = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge HCLK); #1;
      checks++;
      if (an !== 8'(1 << (k % 8)) || seg !== 7'h3F) begin
        errors++;
        $display("FAIL reset_rotate[%0d]: an=%h seg=%h, expected an=%h seg=3f", k, an, seg, 8'(1 << (k % 8)));
      end
    end
    ahb_read(32'h0C, rd);
    checks++;
    if (rd !== 32'h0000_0001) begin
      errors++; $display("FAIL reset_ctrl: read %h, expected 00000001", rd);
    end
    ahb_read(32'h00, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL reset_data: read %h, expected 00000000", rd);
    end
  endtask

  task automatic test_data_rw();
    logic [31:0] rd;
    logic [6:0]  exp_seg [8] = '{7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F};
    int          d;
    ahb_write(32'h00, 3'b010, 32'h89AB_CDEF);
    ahb_read(32'h00, rd);
    checks++;
    if (rd !== 32'h89AB_CDEF) begin
      errors++; $display("FAIL data_word: read %h, expected 89abcdef", rd);
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge HCLK); #1;
      d = an_to_idx(an);
      checks++;
      if (d < 0) begin
        errors++; $display("FAIL data_scan_onehot: an=%h, expected one-hot", an);
      end else if (seg !== exp_seg[d]) begin
        errors++; $display("FAIL data_scan_seg[%0d]: seg=%h, expected %h", d, seg, exp_seg[d]);
      end
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    ahb_write(32'h00, 3'b010, 32'h0);
    ahb_write(32'h01, 3'b000, 32'h5A5A_5A5A);
    ahb_read(32'h00, rd);
    checks++;
    if (rd !== 32'h0000_5A00) begin
      errors++; $display("FAIL byte_write: read %h, expected 00005a00", rd);
    end
    ahb_write(32'h02, 3'b001, 32'hBEEF_BEEF);
    ahb_read(32'h00, rd);
    checks++;
    if (rd !== 32'hBEEF_5A00) begin
      errors++; $display("FAIL half_write: read %h, expected beef5a00", rd);
    end
    ahb_write(32'h18, 3'b010, 32'hFFFF_FFFF);
    ahb_read(32'h18, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL raz_0x18: read %h, expected 00000000", rd);
    end
    ahb_write(32'h0C, 3'b010, 32'hFFFF_FFFF);
    ahb_read(32'h0C, rd);
    checks++;
`ifdef SEG_DIM_EN
    if (rd !== 32'hFFFF_0F01) begin
      errors++; $display("FAIL ctrl_readback: read %h, expected ffff0f01", rd);
    end
`else
    if (rd !== 32'hFFFF_0001) begin
      errors++; $display("FAIL ctrl_readback: read %h, expected ffff0001", rd);
    end
`endif
    ahb_write(32'h0C, 3'b010, 32'h0000_0001);
  endtask

  task automatic test_back_to_back();
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h04; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    HWDATA = 32'h0000_00A5; HWRITE = 1'b0; HADDR = 32'h04;
    checks++;
    if (HRDATA !== 32'h0) begin
      errors++; $display("FAIL b2b_write_phase_rdata: HRDATA=%h, expected 00000000", HRDATA);
    end
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = '0;
    checks++;
    if (HRDATA !== 32'h0000_00A5) begin
      errors++; $display("FAIL b2b_read: HRDATA=%h, expected 000000a5", HRDATA);
    end
    @(posedge HCLK); #1;
    checks++;
    if (HRDATA !== 32'h0) begin
      errors++; $display("FAIL idle_rdata: HRDATA=%h, expected 00000000", HRDATA);
    end
  endtask

  task automatic test_dp_blank();
    int d;
    ahb_write(32'h00, 3'b010, 32'h7654_3210);
    ahb_write(32'h04, 3'b010, 32'h0000_0005);
    ahb_write(32'h08, 3'b010, 32'h0000_0002);
    for (int k = 0; k < 8; k++) begin
      @(posedge HCLK); #1;
      d = an_to_idx(an);
      checks++;
      if (d < 0) begin
        errors++; $display("FAIL blank_onehot: an=%h, expected one-hot", an);
      end else if (seg !== ((d == 1) ? 7'h00 : lut[d]) || dp !== (d == 0 || d == 2)) begin
        errors++;
        $display("FAIL dp_blank[%0d]: seg=%h dp=%b, expected seg=%h dp=%b", d, seg, dp,
                 (d == 1) ? 7'h00 : lut[d], (d == 0 || d == 2));
      end
    end
    ahb_write(32'h04, 3'b010, 32'h0);
    ahb_write(32'h08, 3'b010, 32'h0);
  endtask

  task automatic test_enable();
    logic [31:0] rd;
    logic        seen_other = 1'b0;
    logic        found = 1'b0;
    int          n_on = 0;
    logic        moved = 1'b0;
    ahb_write(32'h0C, 3'b010, 32'h0070_0001);
    for (int i = 0; i < 1500 && !found; i++) begin
      ahb_read(32'h10, rd);
      if (rd[2:0] == 3'd3 && seen_other) found = 1'b1;
      else if (rd[2:0] != 3'd3) seen_other = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL en_find_digit3: STATUS never entered digit 3, last %h", rd);
    end
    ahb_write(32'h0C, 3'b010, 32'h0070_0000);
    checks++;
    if (an !== 8'h08) begin
      errors++; $display("FAIL en_before_off: an=%h, expected 08", an);
    end
    @(posedge HCLK); #1;
    checks++;
    if (an !== 8'h00 || seg !== 7'h00 || dp !== 1'b0) begin
      errors++; $display("FAIL en_off_pins: an=%h seg=%h dp=%b, expected 00/00/0", an, seg, dp);
    end
    repeat (200) @(posedge HCLK);
    #1;
    ahb_read(32'h10, rd);
    checks++;
    if (rd !== 32'h0000_0003) begin
      errors++; $display("FAIL en_off_status: read %h, expected 00000003", rd);
    end
    ahb_write(32'h0C, 3'b010, 32'h0070_0001);
    for (int i = 0; i < 400 && !moved; i++) begin
      @(posedge HCLK); #1;
      if (an === 8'h08) n_on++;
      else if (an === 8'h10) moved = 1'b1;
    end
    checks++;
    if (!moved || n_on != 113) begin
      errors++; $display("FAIL en_resume_slot: digit3 cycles=%0d moved_to_4=%b, expected 113 and 1", n_on, moved);
    end
    ahb_read(32'h10, rd);
    checks++;
    if (rd !== 32'h0000_0104) begin
      errors++; $display("FAIL en_on_status: read %h, expected 00000104", rd);
    end
    ahb_write(32'h0C, 3'b010, 32'h0000_0001);
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h04; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    bus_idle(); HWDATA = 32'h0000_00FF;
    #2 HRESET = 1'b1;
    @(posedge HCLK); #1;
    HWDATA = '0;
    checks++;
    if (an !== 8'h01 || seg !== 7'h3F) begin
      errors++; $display("FAIL midreset_pins: an=%h seg=%h, expected 01/3f", an, seg);
    end
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    ahb_read(32'h04, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL midreset_dpmask: read %h, expected 00000000", rd);
    end
    ahb_read(32'h00, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL midreset_data: read %h, expected 00000000", rd);
    end
  endtask

  initial begin
    test_reset();
    test_data_rw();
    test_byte_lanes();
    test_back_to_back();
    test_dp_blank();
    test_enable();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
